// File: rtl/bus_arbiter_pkg.sv
// Shared CGRA bus definitions: arbiter FSM encoding, default sizing and small helpers.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arbState_t;

  localparam int DEF_N_PE    = 4;
  localparam int DEF_TIMEOUT = 16;

  // Index increment that wraps at n.
  function automatic int wrapInc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus bundle between the PE requesters / global memory and the arbiter.
interface bus_arbiter_if #(
  parameter int N_PE = 4
);
  // A PE holds bus_request until it sees its grant bit; the transaction belongs to that PE
  // until global memory answers with mem_ack_in (or the arbiter times out), which the PE
  // sees as a one-cycle mem_ack_out pulse (or timeout_err) while grant drops.
  logic [N_PE-1:0]         bus_request;
  logic [N_PE-1:0]         grant;
  logic [32*N_PE-1:0]      mem_address_in;
  logic [32*N_PE-1:0]      result_in;
  logic [N_PE-1:0]         mem_read_in;
  logic [N_PE-1:0]         mem_write_in;
  logic [31:0]             mem_address_out;
  logic [31:0]             result_out;
  logic                    mem_read_out;
  logic                    mem_write_out;
  logic                    mem_ack_in;
  logic [N_PE-1:0]         mem_ack_out;
  logic [$clog2(N_PE)-1:0] owner;
  logic                    timeout_err;

  modport master (
    input  bus_request, mem_address_in, result_in, mem_read_in, mem_write_in, mem_ack_in,
    output grant, mem_address_out, result_out, mem_read_out, mem_write_out, mem_ack_out,
    output owner, timeout_err
  );

  modport slave (
    output bus_request, mem_address_in, result_in, mem_read_in, mem_write_in, mem_ack_in,
    input  grant, mem_address_out, result_out, mem_read_out, mem_write_out, mem_ack_out,
    input  owner, timeout_err
  );
endinterface

// File: rtl/bus_arbiter_rr_select.sv
// Combinational round-robin pick: first set request bit scanning upward from rr_ptr.
module rr_select
  import bus_arbiter_pkg::*;
#(
  parameter  int N_PE = DEF_N_PE,
  localparam int IW   = $clog2(N_PE)
) (
  input  logic [N_PE-1:0] request,
  input  logic [IW-1:0]   rr_ptr,
  output logic            valid,
  output logic [IW-1:0]   index
);

  logic [IW-1:0] cand;

  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = 0; i < N_PE; i++) begin
      cand = IW'((int'(rr_ptr) + i) % N_PE);
      if (!valid && request[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared global-memory bus with ack/timeout release.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_PE    = DEF_N_PE,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.master bus,
  output arbState_t     dbgState
);

  localparam int IW = $clog2(N_PE);
  localparam int CW = $clog2(TIMEOUT + 1);

  arbState_t       state;
  logic [IW-1:0]   ownerQ;
  logic [IW-1:0]   rrPtr;
  logic [CW-1:0]   toCnt;
  logic [CW-1:0]   toCntNext;
  logic [N_PE-1:0] grantQ;
  logic [N_PE-1:0] ackQ;
  logic            toErrQ;
  logic            winValid;
  logic [IW-1:0]   winIdx;

  rr_select #(.N_PE(N_PE)) uSelect (
    .request (bus.bus_request),
    .rr_ptr  (rrPtr),
    .valid   (winValid),
    .index   (winIdx)
  );

  assign toCntNext = toCnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ownerQ <= '0;
      rrPtr  <= '0;
      toCnt  <= '0;
      grantQ <= '0;
      ackQ   <= '0;
      toErrQ <= 1'b0;
    end else begin
      ackQ   <= '0;
      toErrQ <= 1'b0;
      case (state)
        IDLE: begin
          if (winValid) begin
            ownerQ <= winIdx;
            grantQ <= N_PE'(1) << winIdx;
            toCnt  <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          // An ack landing on the last allowed cycle still wins over the timeout.
          if (bus.mem_ack_in) begin
            ackQ   <= grantQ;
            grantQ <= '0;
            state  <= RELEASE;
          end else if (toCntNext == CW'(TIMEOUT)) begin
            toCnt  <= toCntNext;
            toErrQ <= 1'b1;
            grantQ <= '0;
            state  <= RELEASE;
          end else begin
            toCnt <= toCntNext;
          end
        end
        RELEASE: begin
          rrPtr <= IW'(wrapInc(int'(ownerQ), N_PE));
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Owner's request path is only visible toward memory while the transaction is live.
  always_comb begin
    bus.mem_address_out = '0;
    bus.result_out      = '0;
    bus.mem_read_out    = 1'b0;
    bus.mem_write_out   = 1'b0;
    if (state == BUSY) begin
      bus.mem_address_out = 32'(bus.mem_address_in >> {ownerQ, 5'd0});
      bus.result_out      = 32'(bus.result_in >> {ownerQ, 5'd0});
      bus.mem_read_out    = bus.mem_read_in[ownerQ];
      bus.mem_write_out   = bus.mem_write_in[ownerQ];
    end
  end

  assign bus.grant       = grantQ;
  assign bus.mem_ack_out = ackQ;
  assign bus.timeout_err = toErrQ;
  assign bus.owner       = ownerQ;
  assign dbgState        = state;

endmodule
